weight_bram_arbiter: RTL

//  Shares the single read-only weight BRAM port between NUM_REQ weight loaders, one per layer.

---
 rtl/weight_arb_pkg.sv | 25 ++
 rtl/weight_bram_arbiter_rr_picker.sv | 49 ++++
 rtl/weight_bram_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/weight_arb_pkg.sv
// ============================================================================
// Module : weight_arb_pkg
// Brief  : Shared FSM encoding and default widths for the weight BRAM arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package weight_arb_pkg;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_W          = 8;
   localparam int DEF_ADDR_WIDTH = 15;
   localparam int DEF_LEN_W      = 16;
   localparam int DEF_READ_LAT   = 2;
   localparam int DEF_ID_W       = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/weight_bram_arbiter_rr_picker.sv
// ============================================================================
// Module : rr_picker
// Brief  : Combinational winner select; round-robin from ptr, or fixed lowest
//          index first when WEIGHT_ARB_FIXED_PRIO_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker
   import weight_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = DEF_ID_W
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

`ifdef WEIGHT_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;
`endif

   always_comb begin : pick
      int cand;
      cand   = 0;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
`ifdef WEIGHT_ARB_FIXED_PRIO_EN
         cand = i;
`else
         cand = (int'(ptr) + i) % NUM_REQ;
`endif
         if (!any && req[cand]) begin
            any          = 1'b1;
            onehot[cand] = 1'b1;
            idx          = ID_W'(cand);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/weight_bram_arbiter.sv
// ============================================================================
// Module : weight_bram_arbiter
// Brief  : Shares one read-only weight BRAM port among NUM_REQ burst loaders and
//          returns a tagged, latency-aligned read stream.
//          Option: WEIGHT_ARB_FIXED_PRIO_EN selects fixed priority arbitration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module weight_bram_arbiter
   import weight_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int W          = DEF_W,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_W      = DEF_LEN_W,
   parameter int READ_LAT   = DEF_READ_LAT,
   parameter int ID_W       = DEF_ID_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] base_addr,
   input  logic [NUM_REQ*LEN_W-1:0]      burst_len,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            done,
   output logic                          rd_valid,
   output logic [W-1:0]                  rd_data,
   output logic [ID_W-1:0]               rd_id,
   output logic                          rd_last,
   output logic                          bram_en,
   output logic                          bram_ren,
   output logic                          bram_wen,
   output logic [ADDR_WIDTH-1:0]         bram_addr,
   input  logic [W-1:0]                  bram_dout
);

   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

   arb_state_t              state, state_nxt;
   logic [NUM_REQ-1:0]      pick_onehot;
   logic [ID_W-1:0]         pick_idx;
   logic                    pick_any;
   logic [ID_W-1:0]         rr_ptr;
   logic [ID_W-1:0]         win_idx;
   logic [ADDR_WIDTH-1:0]   cur_addr;
   logic [LEN_W-1:0]        remaining;
   logic [ADDR_WIDTH-1:0]   sel_base;
   logic [LEN_W-1:0]        sel_len;
   logic [READ_LAT-1:0]     pipe_vld;
   logic [READ_LAT-1:0]     pipe_last;
   logic                    pipe_empty;
   logic                    accept;
   logic                    issue;
   logic                    issue_last;
   logic                    finish;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req    (req),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      sel_base = '0;
      sel_len  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_onehot[i]) begin
            sel_base = base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_len  = burst_len[i*LEN_W +: LEN_W];
         end
      end
   end

   assign pipe_empty = ~|pipe_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      issue      = 1'b0;
      issue_last = 1'b0;
      finish     = 1'b0;
      bram_en    = 1'b0;
      bram_ren   = 1'b0;
      bram_addr  = '0;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               accept    = 1'b1;
               state_nxt = (sel_len == '0) ? ST_DRAIN : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            issue      = 1'b1;
            issue_last = (remaining == LEN_W'(1));
            bram_en    = 1'b1;
            bram_ren   = 1'b1;
            bram_addr  = cur_addr;
            if (issue_last) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Hold the enable until the last read has left the BRAM pipeline.
            bram_en = !pipe_empty;
            if (pipe_empty) begin
               finish    = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bram_wen = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant     <= '0;
         done      <= '0;
         rr_ptr    <= '0;
         win_idx   <= '0;
         cur_addr  <= '0;
         remaining <= '0;
      end else begin
         done <= '0;
         if (accept) begin
            grant     <= pick_onehot;
            win_idx   <= pick_idx;
            cur_addr  <= sel_base;
            remaining <= sel_len;
         end else if (issue) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_W'(1);
         end
         if (finish) begin
            grant  <= '0;
            done   <= grant;
            rr_ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + ID_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld  <= '0;
         pipe_last <= '0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_id     <= '0;
         rd_data   <= '0;
      end else begin
         pipe_vld[0]  <= issue;
         pipe_last[0] <= issue_last;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_last[i] <= pipe_last[i-1];
         end
         rd_valid <= pipe_vld[READ_LAT-1];
         rd_last  <= pipe_vld[READ_LAT-1] & pipe_last[READ_LAT-1];
         rd_id    <= pipe_vld[READ_LAT-1] ? win_idx : '0;
         rd_data  <= pipe_vld[READ_LAT-1] ? bram_dout : '0;
      end
   end

endmodule

`default_nettype wire
